cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm_if.sv | 32 +++
 rtl/cpu_control_fsm.sv | 151 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Bundles the signals between the CPU control FSM and the datapath: IR fields, the memory handshake,
// the datapath control strobes and the status outputs.
interface cpu_control_fsm_if;
    logic        addr_mode;
    logic [4:0]  opcode;
    logic        mem_ack;
    logic        acc_zero;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  addr_sel;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic        mdr_load;
    logic        acc_load;
    logic [4:0]  alu_op;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;

    modport master (
        input  addr_mode, opcode, mem_ack, acc_zero,
        output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, mdr_load,
               acc_load, alu_op, halted, illegal, instr_count
    );

    modport slave (
        output addr_mode, opcode, mem_ack, acc_zero,
        input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, mdr_load,
               acc_load, alu_op, halted, illegal, instr_count
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: fetch / decode / indirect / execute / halt sequencing with a
// request-until-ack memory handshake and Mealy load strobes.
module cpu_control_fsm (
    input  logic              clk,
    input  logic              rst_n,
    cpu_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_INDIRECT = 3'd2,
        S_EXECUTE  = 3'd3,
        S_HALT     = 3'd4
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] addr_sel;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       mdr_load;
        logic       acc_load;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LDA = 5'b00001;
    localparam logic [4:0] OP_STA = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_JMP = 5'b00110;
    localparam logic [4:0] OP_JZ  = 5'b00111;
    localparam logic [4:0] OP_HLT = 5'b11111;

    state_e      r_state;
    state_e      w_next_state;
    logic        r_indirect;
    logic [15:0] r_instr_count;
    ctrl_t       w_ctrl;
    logic        w_has_operand;

    assign w_has_operand = (bus.opcode >= OP_LDA) && (bus.opcode <= OP_JZ);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_indirect    <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_indirect <= 1'b0;
            end else if (r_state == S_INDIRECT) begin
                r_indirect <= 1'b1;
            end
            if (w_ctrl.ir_load) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ctrl.ir_load = 1'b1;
                    w_ctrl.pc_inc  = 1'b1;
                    w_next_state   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OP_HLT) begin
                    w_next_state = S_HALT;
                end else if (bus.opcode == OP_NOP) begin
                    w_next_state = S_FETCH;
                end else if (!w_has_operand) begin
                    w_ctrl.illegal = 1'b1;
                    w_next_state   = S_FETCH;
                end else if (bus.addr_mode) begin
                    w_next_state = S_INDIRECT;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_INDIRECT: begin
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.addr_sel = 2'd1;
                if (bus.mem_ack) begin
                    w_ctrl.mdr_load = 1'b1;
                    w_next_state    = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                w_ctrl.addr_sel = r_indirect ? 2'd2 : 2'd1;
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
                        w_ctrl.mem_req = 1'b1;
                        if (bus.mem_ack) begin
                            w_ctrl.acc_load = 1'b1;
                            w_next_state    = S_FETCH;
                        end
                    end
                    OP_STA: begin
                        w_ctrl.mem_req = 1'b1;
                        w_ctrl.mem_we  = 1'b1;
                        if (bus.mem_ack) begin
                            w_next_state = S_FETCH;
                        end
                    end
                    OP_JMP: begin
                        w_ctrl.pc_load = 1'b1;
                        w_next_state   = S_FETCH;
                    end
                    OP_JZ: begin
                        w_ctrl.pc_load = bus.acc_zero;
                        w_next_state   = S_FETCH;
                    end
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_HALT: w_ctrl.halted = 1'b1;
            default: w_next_state = S_FETCH;
        endcase
        // Outputs are forced quiet while reset is held, so a request in flight drops immediately.
        if (!rst_n) begin
            w_ctrl = '0;
        end
    end

    assign bus.mem_req     = w_ctrl.mem_req;
    assign bus.mem_we      = w_ctrl.mem_we;
    assign bus.addr_sel    = w_ctrl.addr_sel;
    assign bus.ir_load     = w_ctrl.ir_load;
    assign bus.pc_inc      = w_ctrl.pc_inc;
    assign bus.pc_load     = w_ctrl.pc_load;
    assign bus.mdr_load    = w_ctrl.mdr_load;
    assign bus.acc_load    = w_ctrl.acc_load;
    assign bus.alu_op      = w_ctrl.acc_load ? bus.opcode : 5'd0;
    assign bus.halted      = w_ctrl.halted;
    assign bus.illegal     = w_ctrl.illegal;
    assign bus.instr_count = r_instr_count;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: instructions are expanded into expected per-cycle
// behaviour from the instruction-level rules, then replayed against the DUT.
module tb_cpu_control_fsm;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [1:0]  sel;
        logic        ir_load;
        logic        pc_inc;
        logic        pc_load;
        logic        mdr_load;
        logic        acc_load;
        logic [4:0]  alu_op;
        logic        halted;
        logic        illegal;
        logic [15:0] count;
    } obs_t;

    typedef struct {
        logic [15:0] ir;
        logic        ack;
        logic        azero;
        obs_t        exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    vec_t        q[$];
    logic [15:0] m_ir    = 16'h0000;
    logic [15:0] m_count = 16'h0000;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.req      = bus.mem_req;
        o.we       = bus.mem_we;
        o.sel      = bus.addr_sel;
        o.ir_load  = bus.ir_load;
        o.pc_inc   = bus.pc_inc;
        o.pc_load  = bus.pc_load;
        o.mdr_load = bus.mdr_load;
        o.acc_load = bus.acc_load;
        o.alu_op   = bus.alu_op;
        o.halted   = bus.halted;
        o.illegal  = bus.illegal;
        o.count    = bus.instr_count;
        return o;
    endfunction

    function automatic obs_t base();
        obs_t e = '0;
        e.count = m_count;
        return e;
    endfunction

    task automatic push(input logic ack, input logic azero, input obs_t e);
        vec_t v;
        v.ir = m_ir; v.ack = ack; v.azero = azero; v.exp = e;
        q.push_back(v);
    endtask

    task automatic drive(input logic [15:0] ir, input logic ack, input logic azero);
        bus.addr_mode = ir[15];
        bus.opcode    = ir[14:10];
        bus.mem_ack   = ack;
        bus.acc_zero  = azero;
    endtask

    task automatic compare(input string name, input obs_t exp);
        obs_t got = observe();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic run_queue(input string name);
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            drive(v.ir, v.ack, v.azero);
            #2;
            compare(name, v.exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(16'h0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_count = 16'h0000;
    endtask

    // One memory phase: wait_n idle-ack cycles, then the ack cycle carrying the Mealy strobe.
    // kind: 0 = no strobe, 1 = mdr_load, 2 = acc_load.
    task automatic push_mem(input logic [1:0] sel, input logic we, input int wait_n, input int kind);
        obs_t e;
        for (int i = 0; i < wait_n; i++) begin
            e = base(); e.req = 1'b1; e.we = we; e.sel = sel;
            push(1'b0, rbit(), e);
        end
        e = base(); e.req = 1'b1; e.we = we; e.sel = sel;
        if (kind == 1) e.mdr_load = 1'b1;
        if (kind == 2) begin
            e.acc_load = 1'b1;
            e.alu_op   = m_ir[14:10];
        end
        push(1'b1, rbit(), e);
    endtask

    task automatic push_fetch(input logic [15:0] word, input int wait_n);
        obs_t e;
        for (int i = 0; i < wait_n; i++) begin
            e = base(); e.req = 1'b1;
            push(1'b0, rbit(), e);
        end
        e = base(); e.req = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
        push(1'b1, rbit(), e);
        m_ir = word;
        m_count++;
    endtask

    task automatic push_decode();
        obs_t e = base();
        int   op = int'(m_ir[14:10]);
        e.illegal = !((op <= 7) || (op == 31));
        push(rbit(), rbit(), e);
    endtask

    // jz_zero: 0/1 forces acc_zero in the JZ execute cycle, -1 picks it at random.
    task automatic push_instr(input logic [15:0] word, input int wf, input int wi, input int wx,
                              input int halt_cycles, input int jz_zero);
        obs_t       e;
        int         op   = int'(word[14:10]);
        logic [1:0] sel  = word[15] ? 2'd2 : 2'd1;
        logic       az;
        push_fetch(word, wf);
        push_decode();
        if (op == 31) begin
            for (int i = 0; i < halt_cycles; i++) begin
                e = base(); e.halted = 1'b1;
                push(1'(i % 2), rbit(), e);
            end
            return;
        end
        if (op == 0 || op > 7) return;
        if (word[15]) push_mem(2'd1, 1'b0, wi, 1);
        case (op)
            1, 3, 4, 5: push_mem(sel, 1'b0, wx, 2);
            2:          push_mem(sel, 1'b1, wx, 0);
            6: begin
                e = base(); e.sel = sel; e.pc_load = 1'b1;
                push(rbit(), rbit(), e);
            end
            default: begin
                az = (jz_zero < 0) ? rbit() : 1'(jz_zero);
                e = base(); e.sel = sel; e.pc_load = az;
                push(rbit(), az, e);
            end
        endcase
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(16'($urandom), 1'b1, rbit());
            #2;
            compare("reset_quiet", '0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        m_count = 16'h0000;
        drive(16'h0000, 1'b0, 1'b0);
        #2;
        e = base(); e.req = 1'b1;
        compare("reset_release_fetch", e);
    endtask

    task automatic test_lda_direct();
        do_reset();
        push_instr(16'h0405, 0, 0, 0, 0, -1);
        push_instr(16'h0000, 0, 0, 0, 0, -1);
        run_queue("lda_direct");
    endtask

    task automatic test_sta_indirect();
        do_reset();
        push_instr(16'h8805, 2, 2, 2, 0, -1);
        run_queue("sta_indirect");
    endtask

    task automatic test_jz();
        do_reset();
        push_instr(16'h1C10, 0, 0, 0, 0, 0);
        push_instr(16'h1C10, 1, 0, 0, 0, 1);
        push_instr(16'h9C10, 0, 1, 0, 0, 1);
        run_queue("jz");
    endtask

    task automatic test_illegal_halt();
        do_reset();
        push_instr(16'h2800, 1, 0, 0, 0, -1);
        push_instr(16'h7C00, 0, 0, 0, 100, -1);
        run_queue("illegal_halt");
    endtask

    task automatic test_reset_mid_indirect();
        obs_t e;
        do_reset();
        push_fetch(16'h8405, 0);
        push_decode();
        for (int i = 0; i < 2; i++) begin
            e = base(); e.req = 1'b1; e.sel = 2'd1;
            push(1'b0, rbit(), e);
        end
        run_queue("mid_indirect_wait");
        @(negedge clk);
        drive(16'h8405, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compare("mid_indirect_async_drop", '0);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #2;
        compare("mid_indirect_late_ack", '0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_count = 16'h0000;
        bus.mem_ack = 1'b0;
        #2;
        e = base(); e.req = 1'b1;
        compare("mid_indirect_refetch", e);
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [8] = '{16'h0400, 16'h0C00, 16'h1000, 16'h1400,
                                  16'h0800, 16'h1800, 16'h0000, 16'h8C00};
        do_reset();
        foreach (prog[i]) push_instr(prog[i], 0, 0, 0, 0, -1);
        run_queue("back_to_back");
    endtask

    task automatic test_random();
        logic [15:0] word;
        int          op;
        do_reset();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) op = $urandom_range(8, 30);
            else                           op = $urandom_range(0, 7);
            word = {rbit(), 5'(op), 10'($urandom)};
            push_instr(word, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), 0, -1);
        end
        run_queue("random");
    endtask

    task automatic test_count_wrap();
        obs_t e;
        do_reset();
        drive(16'h0000, 1'b1, 1'b0);
        repeat (2 * 65535) @(negedge clk);
        #2;
        e = '0; e.req = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1; e.count = 16'hFFFF;
        compare("count_at_ffff", e);
        @(negedge clk);
        #2;
        e = '0; e.count = 16'h0000;
        compare("count_wrap", e);
    endtask

    initial begin
        drive(16'h0000, 1'b0, 1'b0);
        test_reset();
        test_lda_direct();
        test_sta_indirect();
        test_jz();
        test_illegal_halt();
        test_reset_mid_indirect();
        test_back_to_back();
        test_random();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
